perf_counter_bank: RTL

- Hardware-side performance counter bank for the NPC core.
- Taps the same pipeline, icache and LSU event signals that the simulation perf hooks report to the C++ harness, and accumulates them in on-chip counters.
- Software or the debug harness reads and clears the counters over a simple request/response register port.
- Sits beside the core; observes only and never stalls any pipeline stage.

---
 rtl/perf_counter_bank.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank
//   Passive performance counter bank for the NPC core. It taps pipeline,
//   icache and LSU event signals and accumulates them in eight counters.
//   The counters are read, written and cleared through a request/response
//   register port. The bank only observes the core and never stalls it.
//
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   ifu_valid, idu_ready                fetch handshake (counter 2)
//   exu_valid                           retire strobe (counter 1)
//   icache_valid, icache_isHit          icache lookup result (counters 3/4)
//   lsu_ren, lsu_wen, lsu_isWaiting     LSU activity (counters 5/6/7)
//   req_valid/req_ready/req_wen/
//   req_addr/req_wdata                  register request channel
//   resp_valid/resp_ready/
//   resp_rdata/resp_err                 register response channel
//
// Register map
//   0x00 + 8*i : counter i [31:0]
//   0x04 + 8*i : counter i [CNT_WIDTH-1:32], zero-extended
//   0x40       : bit0 enable (R/W), bit1 clear (write-1, reads 0)
module perf_counter_bank #(
  parameter int unsigned CNT_WIDTH = 64,
  parameter bit          EN_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifu_valid,
  input  logic        idu_ready,
  input  logic        exu_valid,
  input  logic        icache_valid,
  input  logic        icache_isHit,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic        lsu_isWaiting,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned NUM_CNT   = 8;
  localparam int unsigned HI_WIDTH  = CNT_WIDTH - 32;
  localparam logic [7:0]  CTRL_ADDR = 8'h40;

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic                 enable;
  logic                 clear_pend;
  logic                 wait_q;
  logic [HI_WIDTH-1:0]  snap;
  logic [2:0]           snap_idx;
  logic                 snap_valid;
  logic [NUM_CNT-1:0]   inc;

  // Request decode
  logic        accept;
  logic [2:0]  acc_idx;
  logic        acc_hi;
  logic        acc_err;
  logic        acc_ctrl;
  logic        cnt_wr;
  logic [31:0] rdata_nxt;

  assign accept   = (state == S_IDLE) && req_valid;
  assign acc_idx  = req_addr[5:3];
  assign acc_hi   = req_addr[2];
  assign acc_err  = (req_addr[1:0] != 2'b00) || (req_addr > CTRL_ADDR);
  assign acc_ctrl = (req_addr == CTRL_ADDR);
  assign cnt_wr   = accept && req_wen && !acc_err && !acc_ctrl;

  // Per-counter increment requests for this cycle.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    inc = '0;
    if (enable) begin
      inc[0] = 1'b1;
      inc[1] = exu_valid;
      inc[2] = ifu_valid && idu_ready;
      inc[3] = icache_valid && icache_isHit;
      inc[4] = icache_valid && !icache_isHit;
      // Loads/stores are counted once per memory wait, on its rising edge.
      inc[5] = lsu_isWaiting && !wait_q && lsu_ren;
      inc[6] = lsu_isWaiting && !wait_q && lsu_wen;
      inc[7] = lsu_isWaiting;
    end
  end

  // Read data for the request being accepted this cycle; 0 for writes/errors.
  always_comb begin
    rdata_nxt = '0;
    if (!acc_err && !req_wen) begin
      if (acc_ctrl) begin
        rdata_nxt = {31'd0, enable};
      end else if (!acc_hi) begin
        rdata_nxt = cnt[acc_idx][31:0];
      end else if (snap_valid && (snap_idx == acc_idx)) begin
        // High half captured at the matching low read: a carry in between
        // cannot tear the 64-bit value seen by software.
        rdata_nxt = 32'(snap);
      end else begin
        rdata_nxt = 32'(cnt[acc_idx][CNT_WIDTH-1:32]);
      end
    end
  end

  // Counter array.
  // NOTE: the counters are plain flops, not a RAM, and software must see
  // zeros after reset, so the whole array is reset explicitly.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (clear_pend) begin
          cnt[i] <= '0;
        end else if (cnt_wr && (acc_idx == 3'(i))) begin
          // A software write wins over a same-cycle increment.
          if (acc_hi) cnt[i][CNT_WIDTH-1:32] <= req_wdata[HI_WIDTH-1:0];
          else        cnt[i][31:0]           <= req_wdata;
        end else if (inc[i]) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Control, snapshot and response registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable     <= EN_RESET;
      clear_pend <= 1'b0;
      wait_q     <= 1'b0;
      snap       <= '0;
      snap_idx   <= '0;
      snap_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      wait_q     <= lsu_isWaiting;
      clear_pend <= 1'b0;
      if (accept) begin
        resp_rdata <= rdata_nxt;
        resp_err   <= acc_err;
        if (req_wen && acc_ctrl) begin
          enable     <= req_wdata[0];
          clear_pend <= req_wdata[1];
        end
        if (!req_wen && !acc_err && !acc_ctrl && !acc_hi) begin
          snap       <= cnt[acc_idx][CNT_WIDTH-1:32];
          snap_idx   <= acc_idx;
          snap_valid <= 1'b1;
        end
      end
    end
  end

  // Register port FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Register port FSM: next state and handshake outputs
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
